// File: rtl/bias_pkg.sv
// rtl/bias_pkg.sv - shared sizes and FSM encoding for the bias RAM loader
// Contents:
//   BIAS_DEPTH / BIAS_ADDR_W / BIAS_DATA_W : bias table geometry
//   bias_state_e                           : loader FSM states
//   bias_len_ok()                          : legal load length check
package bias_pkg;

  localparam int BIAS_DEPTH  = 128;
  localparam int BIAS_ADDR_W = 7;
  localparam int BIAS_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } bias_state_e;

  // A load must cover at least one entry and must not run past the table.
  function automatic logic bias_len_ok(input logic [BIAS_ADDR_W:0] len);
    return (len != '0) && (len <= (BIAS_ADDR_W + 1)'(BIAS_DEPTH));
  endfunction

endpackage

// File: rtl/bias_ram_sp.sv
// rtl/bias_ram_sp.sv - DEPTH x DATA_W bias RAM, one write port, registered read-first read port
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset (read register only)
//   we_i, wr_addr_i,
//   wr_data_i           : write port
//   rd_en_i, rd_addr_i  : read strobe and address
//   rd_data_o           : read data, one cycle after rd_en_i, held otherwise
module bias_ram_sp
  import bias_pkg::*;
#(
  parameter int DEPTH  = BIAS_DEPTH,
  parameter int ADDR_W = BIAS_ADDR_W,
  parameter int DATA_W = BIAS_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Array has no reset so it maps onto block/distributed RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // The read samples the array before this edge's write lands: read-first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bias_rom_loader.sv
// rtl/bias_rom_loader.sv - fills the bias RAM from a byte stream and exposes a read port
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   start_i, len_i        : begin a load of len_i bytes (1..DEPTH), sampled in IDLE
//   s_valid_i, s_data_i,
//   s_ready_o             : byte stream handshake
//   busy_o, done_o, err_o : load in progress / last byte written pulse / bad len pulse
//   loaded_o, checksum_o  : complete load present / byte sum of current or last load
//   rd_en_i, rd_addr_i,
//   rd_data_o             : engine read port, one cycle latency
module bias_rom_loader
  import bias_pkg::*;
#(
  parameter int DEPTH  = BIAS_DEPTH,
  parameter int ADDR_W = BIAS_ADDR_W,
  parameter int DATA_W = BIAS_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              loaded_o,
  output logic [DATA_W-1:0] checksum_o,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  bias_state_e       state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              loaded_q, loaded_d;
  logic              err_q, err_d;
  logic              len_ok;
  logic              accept;

  assign len_ok = (len_i != '0) && (len_i <= DEPTH_L);
  assign accept = (state_q == LOAD) && s_valid_i;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    checksum_d = checksum_q;
    loaded_d   = loaded_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_ok) begin
            len_d      = len_i;
            count_d    = '0;
            wr_ptr_d   = '0;
            checksum_d = '0;
            loaded_d   = 1'b0;
            state_d    = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wr_ptr_d   = wr_ptr_q + 1'b1;
          count_d    = count_q + 1'b1;
          checksum_d = checksum_q + s_data_i;
          // Accepting byte number len ends the load; loaded rises with done.
          if (count_q + 1'b1 == len_q) begin
            state_d  = FIN;
            loaded_d = 1'b1;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      checksum_q <= '0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      checksum_q <= checksum_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
    end
  end

  assign s_ready_o  = (state_q == LOAD);
  assign busy_o     = (state_q == LOAD);
  assign done_o     = (state_q == FIN);
  assign err_o      = err_q;
  assign loaded_o   = loaded_q;
  assign checksum_o = checksum_q;

  // Writes are blocked during reset so an aborted load cannot land a byte.
  bias_ram_sp #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (accept && !rst_i),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (s_data_i),
    .rd_en_i   (rd_en_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );

endmodule

// File: tb/tb_bias_rom_loader.sv
// tb/tb_bias_rom_loader.sv - directed and randomized checks of the bias RAM loader
module tb_bias_rom_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] len = '0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready, busy, done, err, loaded;
  logic [7:0] checksum;
  logic       rd_en = 1'b0;
  logic [6:0] rd_addr = '0;
  logic [7:0] rd_data;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [128];
  logic [7:0] din [128];

  always #5 clk = ~clk;

  bias_rom_loader dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .len_i      (len),
    .s_valid_i  (s_valid),
    .s_data_i   (s_data),
    .s_ready_o  (s_ready),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .loaded_o   (loaded),
    .checksum_o (checksum),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_loaded"}, loaded, 0);
    check({tag, "_checksum"}, checksum, 0);
    check({tag, "_rd_data"}, rd_data, 0);
  endtask

  // Streams din[0..n-1]; stops early after abort_at accepts when abort_at >= 0.
  task automatic run_load(input int n, input bit gapped, input int coll,
                          input int abort_at, input bit noise);
    int         idx = 0;
    int         cyc = 0;
    logic [7:0] sum = '0;
    logic [7:0] old = '0;
    start = 1'b1;
    len   = 8'(n);
    tick();
    start = 1'b0;
    len   = 8'($urandom);
    check("load_busy", busy, 1);
    check("load_ready", s_ready, 1);
    check("load_loaded_clr", loaded, 0);
    check("load_cksum_clr", checksum, 0);
    while (idx < n && cyc < 4 * n + 20) begin
      if (abort_at >= 0 && idx == abort_at) break;
      s_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = s_valid ? din[idx] : 8'($urandom);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        len   = 8'($urandom_range(1, 128));
      end
      if (idx == coll && s_valid) begin
        rd_en   = 1'b1;
        rd_addr = 7'(coll);
        old     = mem[coll];
      end
      check("ready_before_accept", s_ready, 1);
      tick();
      cyc++;
      if (s_valid) begin
        mem[idx] = din[idx];
        sum += din[idx];
        idx++;
      end
      if (rd_en) begin
        check("collision_old_data", rd_data, old);
        rd_en = 1'b0;
      end
      if (idx < n) begin
        check("load_done_early", done, 0);
        check("load_busy_hold", busy, 1);
      end
    end
    s_valid = 1'b0;
    start   = 1'b0;
    if (abort_at < 0) begin
      check("load_within_budget", idx, n);
      check("fin_done", done, 1);
      check("fin_loaded", loaded, 1);
      check("fin_busy", busy, 0);
      check("fin_ready", s_ready, 0);
      check("fin_checksum", checksum, sum);
      tick();
      check("post_done", done, 0);
      check("post_loaded", loaded, 1);
      check("post_checksum", checksum, sum);
      check("post_busy", busy, 0);
    end
  endtask

  task automatic rd(input int a);
    rd_en   = 1'b1;
    rd_addr = 7'(a);
    tick();
    rd_en = 1'b0;
    check("read_data", rd_data, mem[a]);
  endtask

  task automatic illegal(input int n);
    logic prev_loaded;
    prev_loaded = loaded;
    start = 1'b1;
    len   = 8'(n);
    tick();
    start = 1'b0;
    check("illegal_err", err, 1);
    check("illegal_busy", busy, 0);
    check("illegal_ready", s_ready, 0);
    check("illegal_loaded", loaded, prev_loaded);
    tick();
    check("illegal_err_clr", err, 0);
    check("illegal_busy2", busy, 0);
    check("illegal_ready2", s_ready, 0);
  endtask

  initial begin
    // Reset values.
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check_reset_outputs("idle");

    // Full 128-byte load, s_valid held high.
    for (int i = 0; i < 128; i++) din[i] = 8'($urandom);
    din[0] = 8'ha6;
    din[1] = 8'hc5;
    din[5] = 8'h3c;
    run_load(128, 1'b0, -1, -1, 1'b0);
    for (int i = 0; i < 128; i++) rd(i);
    rd_addr = 7'd77;
    tick();
    check("read_hold", rd_data, mem[127]);

    // Gapped 4-byte load.
    din[0] = 8'h09;
    din[1] = 8'h0e;
    din[2] = 8'h82;
    din[3] = 8'hfa;
    run_load(4, 1'b1, -1, -1, 1'b0);
    for (int i = 0; i < 8; i++) rd(i);

    // Illegal lengths.
    illegal(0);
    illegal(129);
    illegal($urandom_range(130, 255));

    // Stream bytes offered in IDLE must not be consumed.
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      tick();
      check("idle_ready", s_ready, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end
    s_valid = 1'b0;
    for (int i = 0; i < 8; i++) rd(i);

    // Read-first collision at addr 5 with start noise during the load.
    for (int i = 0; i < 6; i++) din[i] = 8'($urandom);
    din[5] = 8'h81;
    run_load(6, 1'b0, 5, -1, 1'b1);
    rd(5);
    check("collision_new_data", rd_data, 8'h81);
    for (int i = 0; i < 10; i++) rd(i);

    // Reset after 10 of 20 bytes, then a fresh 20-byte load.
    for (int i = 0; i < 20; i++) din[i] = 8'($urandom);
    run_load(20, 1'b0, -1, 10, 1'b0);
    rst = 1'b1;
    tick();
    check_reset_outputs("abort");
    rst = 1'b0;
    tick();
    check_reset_outputs("abort_idle");
    for (int i = 0; i < 12; i++) rd(i);
    for (int i = 0; i < 20; i++) din[i] = 8'($urandom);
    run_load(20, 1'b1, -1, -1, 1'b0);
    for (int i = 0; i < 24; i++) rd(i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
